serial_7seg_shifter: RTL and testbench

//  Downstream stage of the clock display path. Accepts a 48-bit frame (6 digits x 8 segment

---
 rtl/serial_7seg_shifter_pkg.sv | 21 ++
 rtl/serial_7seg_shifter_phase_timer.sv | 27 ++
 rtl/serial_7seg_shifter.sv | 131 +++++++++++++
 tb/tb_serial_7seg_shifter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_7seg_shifter_pkg.sv
// Shared frame geometry and FSM encoding for the serial 7-segment shifter.
package serial_7seg_shifter_pkg;

  localparam int unsigned NUM_DIGITS = 6;
  localparam int unsigned DIGIT_BITS = 8;
  localparam int unsigned FRAME_W    = NUM_DIGITS * DIGIT_BITS;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLow   = 2'd1,
    StHigh  = 2'd2,
    StLatch = 2'd3
  } state_e;

  // Half-period of the serial clock in system clock cycles.
  function automatic int unsigned half_period(input int unsigned sys_hz,
                                              input int unsigned shift_hz);
    return sys_hz / (2 * shift_hz);
  endfunction

endpackage

// File: rtl/serial_7seg_shifter_phase_timer.sv
// H-cycle phase timer: phase_end is high in the last cycle of a phase started by load.
module shift_phase_timer #(
  parameter int unsigned H = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic phase_end
);

  localparam int unsigned CntW = $clog2(H + 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= CntW'(H - 1);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign phase_end = (cnt_q == '0);

endmodule

// File: rtl/serial_7seg_shifter.sv
// Shifts a 48-bit segment frame MSB-first into a 74HC595-style chain, then pulses the latch.
module serial_7seg_shifter
  import serial_7seg_shifter_pkg::*;
#(
  parameter int unsigned SYS_CLK_HZ   = 5_000_000,
  parameter int unsigned SHIFT_CLK_HZ = 500_000
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_en,
  input  logic               i_start_stb,
  input  logic [FRAME_W-1:0] i_frame,
  output logic               o_busy,
  output logic               o_done_stb,
  output logic               o_serial_data,
  output logic               o_serial_clk,
  output logic               o_serial_latch
);

  // H must be at least 1; the clock ratio is a build-time choice.
  localparam int unsigned H = half_period(SYS_CLK_HZ, SHIFT_CLK_HZ);
  localparam logic [5:0]  LastBit = 6'(FRAME_W - 1);

  state_e             state_q, state_d;
  logic [FRAME_W-1:0] shreg_q, shreg_d;
  logic [5:0]         bit_q, bit_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               data_q, data_d;
  logic               sclk_q, sclk_d;
  logic               latch_q, latch_d;
  logic               load;
  logic               phase_end;

  shift_phase_timer #(
    .H (H)
  ) u_timer (
    .clk       (i_clk),
    .reset     (i_reset),
    .load      (load),
    .phase_end (phase_end)
  );

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bit_d   = bit_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    data_d  = data_q;
    sclk_d  = sclk_q;
    latch_d = latch_q;
    load    = 1'b0;
    case (state_q)
      StIdle: begin
        if (i_start_stb && i_en) begin
          state_d = StLow;
          shreg_d = i_frame;
          bit_d   = '0;
          busy_d  = 1'b1;
          data_d  = i_frame[FRAME_W-1];
          sclk_d  = 1'b0;
          load    = 1'b1;
        end
      end
      StLow: begin
        if (phase_end) begin
          state_d = StHigh;
          sclk_d  = 1'b1;
          load    = 1'b1;
        end
      end
      StHigh: begin
        if (phase_end) begin
          sclk_d = 1'b0;
          load   = 1'b1;
          if (bit_q == LastBit) begin
            state_d = StLatch;
            data_d  = 1'b0;
            latch_d = 1'b1;
          end else begin
            // Data only moves on LOW entry, giving H cycles of setup and hold.
            state_d = StLow;
            shreg_d = shreg_q << 1;
            bit_d   = bit_q + 1'b1;
            data_d  = shreg_q[FRAME_W-2];
          end
        end
      end
      StLatch: begin
        if (phase_end) begin
          state_d = StIdle;
          latch_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          load    = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= StIdle;
      shreg_q <= '0;
      bit_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= 1'b0;
      sclk_q  <= 1'b0;
      latch_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      data_q  <= data_d;
      sclk_q  <= sclk_d;
      latch_q <= latch_d;
    end
  end

  assign o_busy         = busy_q;
  assign o_done_stb     = done_q;
  assign o_serial_data  = data_q;
  assign o_serial_clk   = sclk_q;
  assign o_serial_latch = latch_q;

endmodule

// File: tb/tb_serial_7seg_shifter.sv
// Scoreboard bench: a behavioural 74HC595 chain model checks every latched frame and its timing.
module tb_serial_7seg_shifter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b1;
  logic        start = 1'b0;
  logic [47:0] frame = '0;
  logic        sel = 1'b0;

  logic busy0, done0, sdata0, sclk0, latch0;
  logic busy1, done1, sdata1, sclk1, latch1;
  logic m_busy, m_done, m_sdata, m_sclk, m_latch;
  logic [31:0] h;

  int unsigned compared = 0;
  int unsigned mismatched = 0;
  int unsigned edge_cnt = 0;
  int unsigned free_at = 0;
  logic [47:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  serial_7seg_shifter #(
    .SYS_CLK_HZ   (5_000_000),
    .SHIFT_CLK_HZ (500_000)
  ) dut_h5 (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_en           (en),
    .i_start_stb    (start),
    .i_frame        (frame),
    .o_busy         (busy0),
    .o_done_stb     (done0),
    .o_serial_data  (sdata0),
    .o_serial_clk   (sclk0),
    .o_serial_latch (latch0)
  );

  serial_7seg_shifter #(
    .SYS_CLK_HZ   (5_000_000),
    .SHIFT_CLK_HZ (2_500_000)
  ) dut_h1 (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_en           (en),
    .i_start_stb    (start),
    .i_frame        (frame),
    .o_busy         (busy1),
    .o_done_stb     (done1),
    .o_serial_data  (sdata1),
    .o_serial_clk   (sclk1),
    .o_serial_latch (latch1)
  );

  assign m_busy  = sel ? busy1  : busy0;
  assign m_done  = sel ? done1  : done0;
  assign m_sdata = sel ? sdata1 : sdata0;
  assign m_sclk  = sel ? sclk1  : sclk0;
  assign m_latch = sel ? latch1 : latch0;
  assign h       = sel ? 32'd1  : 32'd5;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Acceptance model: idle from reset, then free again one edge after the done cycle.
  task automatic send(input logic [47:0] f, output bit accepted);
    int unsigned e;
    e = edge_cnt + 1;
    frame = f;
    start = 1'b1;
    accepted = en && (e >= free_at);
    if (accepted) begin
      exp_q.push_back(f);
      free_at = e + 97 * h + 1;
    end
    cyc(1);
    start = 1'b0;
    frame = 48'({$urandom(), $urandom()});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    exp_q.delete();
    free_at = edge_cnt + 1;
    check("outputs_after_reset",
          {54'd0, busy0, done0, sdata0, sclk0, latch0, busy1, done1, sdata1, sclk1, latch1}, 0);
  endtask

  // Lands on the o_done_stb cycle of the frame in flight.
  task automatic wait_free();
    if (edge_cnt + 1 < free_at) cyc(free_at - edge_cnt - 1);
  endtask

  // Monitor: chain model shifts on sclk rise, captures on latch rise, scores on done.
  logic [47:0] chain = '0, latched = '0, got;
  logic        prev_sclk = 1'b0, prev_latch = 1'b0;
  int unsigned sclk_cnt = 0, latch_cnt = 0, latch_hi = 0, busy_cnt = 0, sclk_total = 0;

  always @(negedge clk) begin
    if (m_sclk === 1'b1 && prev_sclk === 1'b0) begin
      chain = {chain[46:0], m_sdata};
      sclk_cnt++;
      sclk_total++;
    end
    if (m_latch === 1'b1 && prev_latch === 1'b0) begin
      latched = chain;
      latch_cnt++;
    end
    if (m_latch === 1'b1) latch_hi++;
    if (m_latch === 1'b0 && prev_latch === 1'b1) begin
      check("latch_width", 64'(latch_hi), 64'(h));
      latch_hi = 0;
    end
    if (m_busy === 1'b1) busy_cnt++;
    if (m_done === 1'b1) begin
      check("frame_expected", 64'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        got = exp_q.pop_front();
        check("latched_frame", 64'(latched), 64'(got));
      end
      check("busy_cycles", 64'(busy_cnt), 64'(97 * h));
      check("sclk_edges", 64'(sclk_cnt), 48);
      check("latch_pulses", 64'(latch_cnt), 1);
      busy_cnt = 0;
      sclk_cnt = 0;
      latch_cnt = 0;
    end
    prev_sclk = m_sclk;
    prev_latch = m_latch;
    if (reset) begin
      prev_sclk = 1'b0;
      prev_latch = 1'b0;
      busy_cnt = 0;
      sclk_cnt = 0;
      latch_cnt = 0;
      latch_hi = 0;
    end
  end

  initial begin
    bit acc;
    int unsigned snap;
    do_reset();
    do_reset();

    // Single known frame.
    send(48'hA5_3C_FF_00_81_7E, acc);
    wait_free();
    cyc(2);

    // Start while busy is ignored.
    send(48'({$urandom(), $urandom()}), acc);
    cyc(99);
    send(48'h12_34_56_78_9A_BC, acc);
    check("busy_start_ignored", 64'(acc), 0);
    wait_free();
    cyc(2);

    // Enable low blocks a start.
    en = 1'b0;
    snap = sclk_total;
    send(48'hFF_FF_FF_FF_FF_FF, acc);
    cyc(20);
    check("en_low_busy", 64'(m_busy), 0);
    check("en_low_no_sclk", 64'(sclk_total), 64'(snap));
    en = 1'b1;

    // Enable drops at bit 10; frame still completes.
    send(48'({$urandom(), $urandom()}), acc);
    cyc(10 * 2 * 5 + 3);
    en = 1'b0;
    wait_free();
    cyc(2);
    en = 1'b1;

    // Back-to-back: start presented during the done cycle.
    send(48'({$urandom(), $urandom()}), acc);
    wait_free();
    check("done_stb_at_gap", 64'(m_done), 1);
    send(48'({$urandom(), $urandom()}), acc);
    check("back_to_back_accept", 64'(acc), 1);
    wait_free();
    cyc(2);

    // Reset at bit 20 aborts the frame without a latch pulse.
    send(48'({$urandom(), $urandom()}), acc);
    cyc(20 * 2 * 5 + 4);
    snap = latch_cnt;
    do_reset();
    check("abort_no_latch", 64'(latch0), 0);
    cyc(3);
    send(48'h0F_F0_55_AA_C3_3C, acc);
    wait_free();
    cyc(2);

    // Randomised traffic with random enable and gaps.
    for (int i = 0; i < 4; i++) begin
      en = ($urandom_range(0, 3) != 0);
      send(48'({$urandom(), $urandom()}), acc);
      if (acc) wait_free();
      cyc($urandom_range(1, 4));
    end
    en = 1'b1;
    cyc(5);

    // H=1 instance.
    sel = 1'b1;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send(48'({$urandom(), $urandom()}), acc);
      wait_free();
      if (i % 2 == 1) cyc($urandom_range(1, 3));
    end
    cyc(5);

    check("queue_drained", 64'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
